instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL use one clock (iCLK, rising edge) and a synchronous, active-high reset (iRST).
REQ-002 iCLK  input  1  clock.
REQ-003 iRST  input  1  synchronous active-high reset.
REQ-004 iValid  input  1  request present.
REQ-005 oReady  output  1  block can accept a request this cycle.
REQ-006 iClass  input  4  0 LOAD, 1 OPIMM, 2 AUIPC, 3 STORE, 4 RTYPE, 5 LUI, 6 BRANCH, 7 JALR, 8 JAL, 9 MULDIV; others are illegal.
REQ-007 iFunc  input  4  {alt, funct3}; alt selects SUB/SRA.
REQ-008 iRd, iRs1, iRs2  input  5 each  register fields.
REQ-009 iImm  input  32  signed byte-offset or value immediate.
REQ-010 oValid  output  1  encoded word present.
REQ-011 iReady  input  1  downstream accepts the word this cycle.
REQ-012 oInstr  output  32  RV32 instruction word.
REQ-013 oIllegal  output  1  request was unencodable; qualified by oValid.

Function
REQ-014 Transfers SHALL occur only on cycles where valid and ready are both high, on each side.
REQ-015 The pipeline SHALL have 2 register stages: S1 captures the request, S2 holds the assembled word and the illegal flag.
REQ-016 Latency SHALL be 2 cycles from input acceptance to oValid, and throughput SHALL be 1 word per cycle when iReady is held high.
REQ-017 Each stage SHALL advance when it is empty or when the next stage advances.
- oReady = !S1full || S2advance (no combinational path from iValid to oReady).
REQ-018 While oValid=1 and iReady=0, oInstr and oIllegal SHALL stay stable, and no request SHALL be lost or duplicated.
REQ-019 Opcodes SHALL be: LOAD 0000011, OPIMM 0010011, AUIPC 0010111, STORE 0100011, RTYPE and MULDIV 0110011, LUI 0110111, BRANCH 1100011, JALR 1100111, JAL 1101111.
REQ-020 Field placement SHALL follow the RV32I I/S/B/U/J/R formats; fields unused by a format SHALL be zero.
REQ-021 A request SHALL be illegal if any of the following holds:
- LOAD funct3 not in {000,001,010,100,101}.
- STORE funct3 > 010.
- BRANCH funct3 in {010,011}.
- JALR funct3 != 000.
- alt=1, except RTYPE funct3 000/101 or OPIMM funct3 101.
- I/S immediate outside [-2048,2047].
- B immediate outside [-4096,4094], or B immediate odd.
- J immediate outside [-2^20, 2^20-2], or J immediate odd.
- U immediate with imm[11:0] != 0.
- OPIMM shift (funct3 001/101) with imm outside [0,31].
REQ-022 An illegal request SHALL emit oInstr=32'h00000013 (nop) with oIllegal=1, and SHALL still consume one pipeline slot.
REQ-023 OPIMM SRAI SHALL set instr[30]=1; RTYPE alt SHALL set funct7=0100000.

Reset
REQ-024 On iRST=1 at a clock edge, both stages SHALL empty.
- oValid=0, oInstr=0, oIllegal=0; oReady=1 on the following cycle.
REQ-025 A reset in mid-stream SHALL discard in-flight words; iValid during the reset cycle SHALL NOT be accepted.

Configuration
REQ-026 With macro RV32M_EN defined, class 9 SHALL encode funct7=0000001 with funct3=iFunc[2:0]; iFunc[3]=1 SHALL be illegal.
REQ-027 Without RV32M_EN, class 9 SHALL be illegal, and no MULDIV logic SHALL be synthesized.

Verification
REQ-028 OPIMM, rd=1, rs1=0, imm=5, func=0000 -> oInstr=0x00500093 two cycles later, oIllegal=0.
REQ-029 RTYPE, rd=3, rs1=1, rs2=2, func=1000 -> 0x402081B3. BRANCH, rs1=rs2=0, func=0000, imm=-4 -> 0xFE000EE3.
REQ-030 LUI, rd=5, imm=0x12345000 -> 0x123452B7. LUI, imm=0x12345001 -> 0x00000013 with oIllegal=1.
REQ-031 Four back-to-back requests with iReady low for 3 cycles mid-stream -> all four words are delivered in order, unchanged, with oReady low once both stages are full.
REQ-032 MULDIV, rd=1, rs1=2, rs2=3, func=0000 -> 0x023100B3 with RV32M_EN defined; nop with oIllegal=1 without it.
REQ-033 iRST asserted with both stages full -> oValid=0 the next cycle, and neither word ever appears.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder: the request channel (iValid/oReady) and
// the encoded-word channel (oValid/iReady). master = requester side, slave = encoder.
interface instr_encoder_if;
    logic        iValid;
    logic        oReady;
    logic [3:0]  iClass;
    logic [3:0]  iFunc;
    logic [4:0]  iRd;
    logic [4:0]  iRs1;
    logic [4:0]  iRs2;
    logic [31:0] iImm;
    logic        oValid;
    logic        iReady;
    logic [31:0] oInstr;
    logic        oIllegal;

    modport master (
        output iValid, iClass, iFunc, iRd, iRs1, iRs2, iImm, iReady,
        input  oReady, oValid, oInstr, oIllegal
    );

    modport slave (
        input  iValid, iClass, iFunc, iRd, iRs1, iRs2, iImm, iReady,
        output oReady, oValid, oInstr, oIllegal
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32 instruction encoder: S1 captures a request, S2 holds the assembled word.
// Optional macro RV32M_EN enables MULDIV encoding; without it class 9 is illegal.
module instr_encoder (
    input  logic              iCLK,
    input  logic              iRST,
    instr_encoder_if.slave    bus
);
    localparam logic [3:0] C_LOAD   = 4'd0;
    localparam logic [3:0] C_OPIMM  = 4'd1;
    localparam logic [3:0] C_AUIPC  = 4'd2;
    localparam logic [3:0] C_STORE  = 4'd3;
    localparam logic [3:0] C_RTYPE  = 4'd4;
    localparam logic [3:0] C_LUI    = 4'd5;
    localparam logic [3:0] C_BRANCH = 4'd6;
    localparam logic [3:0] C_JALR   = 4'd7;
    localparam logic [3:0] C_JAL    = 4'd8;
`ifdef RV32M_EN
    localparam logic [3:0] C_MULDIV = 4'd9;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        r_s1_full;
    logic [3:0]  r_class;
    logic [3:0]  r_func;
    logic [4:0]  r_rd;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [31:0] r_imm;
    logic        r_s2_full;
    logic [31:0] r_instr;
    logic        r_illegal;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic signed [31:0] w_imm_s;
    logic        w_i_ok;
    logic        w_b_ok;
    logic        w_j_ok;
    logic        w_u_ok;
    logic        w_sh_ok;
    logic        w_alt_ok;
    logic [31:0] w_instr;
    logic        w_ill;

    // Ready depends only on stage occupancy and downstream ready, never on iValid.
    assign w_s2_adv   = !r_s2_full || bus.iReady;
    assign w_s1_adv   = !r_s1_full || w_s2_adv;
    assign bus.oReady = w_s1_adv;
    assign bus.oValid   = r_s2_full;
    assign bus.oInstr   = r_instr;
    assign bus.oIllegal = r_illegal;

    assign w_f3     = r_func[2:0];
    assign w_alt    = r_func[3];
    assign w_imm_s  = $signed(r_imm);
    assign w_i_ok   = (w_imm_s >= -32'sd2048) && (w_imm_s <= 32'sd2047);
    assign w_b_ok   = (w_imm_s >= -32'sd4096) && (w_imm_s <= 32'sd4094) && !r_imm[0];
    assign w_j_ok   = (w_imm_s >= -32'sd1048576) && (w_imm_s <= 32'sd1048574) && !r_imm[0];
    assign w_u_ok   = (r_imm[11:0] == 12'd0);
    assign w_sh_ok  = (r_imm[31:5] == 27'd0);
    assign w_alt_ok = !w_alt
                    || ((r_class == C_RTYPE) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)))
                    || ((r_class == C_OPIMM) && (w_f3 == 3'd5));

    always_comb begin
        w_instr = '0;
        w_ill   = 1'b0;
        case (r_class)
            C_LOAD: begin
                w_ill   = !(w_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || !w_i_ok;
                w_instr = {r_imm[11:0], r_rs1, w_f3, r_rd, OP_LOAD};
            end
            C_OPIMM: begin
                if ((w_f3 == 3'd1) || (w_f3 == 3'd5)) begin
                    w_ill   = !w_sh_ok;
                    w_instr = {1'b0, w_alt, 5'd0, r_imm[4:0], r_rs1, w_f3, r_rd, OP_OPIMM};
                end else begin
                    w_ill   = !w_i_ok;
                    w_instr = {r_imm[11:0], r_rs1, w_f3, r_rd, OP_OPIMM};
                end
            end
            C_AUIPC: begin
                w_ill   = !w_u_ok;
                w_instr = {r_imm[31:12], r_rd, OP_AUIPC};
            end
            C_STORE: begin
                w_ill   = (w_f3 > 3'd2) || !w_i_ok;
                w_instr = {r_imm[11:5], r_rs2, r_rs1, w_f3, r_imm[4:0], OP_STORE};
            end
            C_RTYPE: begin
                w_instr = {1'b0, w_alt, 5'd0, r_rs2, r_rs1, w_f3, r_rd, OP_OP};
            end
            C_LUI: begin
                w_ill   = !w_u_ok;
                w_instr = {r_imm[31:12], r_rd, OP_LUI};
            end
            C_BRANCH: begin
                w_ill   = (w_f3 == 3'd2) || (w_f3 == 3'd3) || !w_b_ok;
                w_instr = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, w_f3,
                           r_imm[4:1], r_imm[11], OP_BRANCH};
            end
            C_JALR: begin
                w_ill   = (w_f3 != 3'd0) || !w_i_ok;
                w_instr = {r_imm[11:0], r_rs1, 3'd0, r_rd, OP_JALR};
            end
            C_JAL: begin
                w_ill   = !w_j_ok;
                w_instr = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, OP_JAL};
            end
`ifdef RV32M_EN
            C_MULDIV: begin
                w_instr = {7'b0000001, r_rs2, r_rs1, w_f3, r_rd, OP_OP};
            end
`endif
            default: w_ill = 1'b1;
        endcase
        // alt is only meaningful for SUB/SRA/SRAI; anywhere else it poisons the request.
        if (!w_alt_ok) begin
            w_ill = 1'b1;
        end
        if (w_ill) begin
            w_instr = NOP;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_s1_full <= 1'b0;
            r_class   <= '0;
            r_func    <= '0;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_imm     <= '0;
            r_s2_full <= 1'b0;
            r_instr   <= '0;
            r_illegal <= 1'b0;
        end else begin
            if (w_s2_adv) begin
                r_s2_full <= r_s1_full;
                if (r_s1_full) begin
                    r_instr   <= w_instr;
                    r_illegal <= w_ill;
                end
            end
            if (w_s1_adv) begin
                r_s1_full <= bus.iValid;
                if (bus.iValid) begin
                    r_class <= bus.iClass;
                    r_func  <= bus.iFunc;
                    r_rd    <= bus.iRd;
                    r_rs1   <= bus.iRs1;
                    r_rs2   <= bus.iRs2;
                    r_imm   <= bus.iImm;
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vector table, stall/reset sequences,
// and randomized traffic scored against a field-arithmetic reference model.
module tb_instr_encoder;
    logic iCLK;
    logic iRST;
    instr_encoder_if u_if ();

    instr_encoder u_dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (u_if.slave)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    typedef struct {
        logic [3:0]  cls;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: assembles fields by arithmetic on the spec's bit positions.
    function automatic logic [32:0] model(input logic [3:0] cls, input logic [3:0] func,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [31:0] imm_u);
        int          imm = int'($signed(imm_u));
        int          f3i = int'(func) % 8;
        bit          alt = (func >= 4'd8);
        bit [31:0]   ib  = imm_u;
        bit [31:0]   f3  = 32'(f3i);
        bit [31:0]   vrd = 32'(rd);
        bit [31:0]   vs1 = 32'(rs1);
        bit [31:0]   vs2 = 32'(rs2);
        bit [31:0]   w   = 0;
        bit          ill = 0;
        bit          i_fit = (imm >= -2048) && (imm <= 2047);
        bit          alt_ok;
        alt_ok = (cls == 4) && (f3i == 0 || f3i == 5) || (cls == 1) && (f3i == 5);
        if (alt && !alt_ok) ill = 1;
        case (int'(cls))
            0: begin
                if (!(f3i inside {0, 1, 2, 4, 5}) || !i_fit) ill = 1;
                w = ((ib & 32'hFFF) << 20) | (vs1 << 15) | (f3 << 12) | (vrd << 7) | 32'h03;
            end
            1: begin
                if (f3i == 1 || f3i == 5) begin
                    if (imm < 0 || imm > 31) ill = 1;
                    w = (alt ? 32'h4000_0000 : 32'h0) | ((ib & 31) << 20) | (vs1 << 15)
                      | (f3 << 12) | (vrd << 7) | 32'h13;
                end else begin
                    if (!i_fit) ill = 1;
                    w = ((ib & 32'hFFF) << 20) | (vs1 << 15) | (f3 << 12) | (vrd << 7) | 32'h13;
                end
            end
            2, 5: begin
                if ((ib & 32'hFFF) != 0) ill = 1;
                w = (ib & 32'hFFFF_F000) | (vrd << 7) | ((cls == 2) ? 32'h17 : 32'h37);
            end
            3: begin
                if (f3i > 2 || !i_fit) ill = 1;
                w = (((ib >> 5) & 127) << 25) | (vs2 << 20) | (vs1 << 15) | (f3 << 12)
                  | ((ib & 31) << 7) | 32'h23;
            end
            4: w = (alt ? 32'h4000_0000 : 32'h0) | (vs2 << 20) | (vs1 << 15) | (f3 << 12)
                 | (vrd << 7) | 32'h33;
            6: begin
                if (f3i == 2 || f3i == 3 || imm < -4096 || imm > 4094 || (imm % 2) != 0) ill = 1;
                w = (((ib >> 12) & 1) << 31) | (((ib >> 5) & 63) << 25) | (vs2 << 20)
                  | (vs1 << 15) | (f3 << 12) | (((ib >> 1) & 15) << 8)
                  | (((ib >> 11) & 1) << 7) | 32'h63;
            end
            7: begin
                if (f3i != 0 || !i_fit) ill = 1;
                w = ((ib & 32'hFFF) << 20) | (vs1 << 15) | (vrd << 7) | 32'h67;
            end
            8: begin
                if (imm < -1048576 || imm > 1048574 || (imm % 2) != 0) ill = 1;
                w = (((ib >> 20) & 1) << 31) | (((ib >> 1) & 1023) << 21)
                  | (((ib >> 11) & 1) << 20) | (((ib >> 12) & 255) << 12)
                  | (vrd << 7) | 32'h6F;
            end
`ifdef RV32M_EN
            9: w = (32'd1 << 25) | (vs2 << 20) | (vs1 << 15) | (f3 << 12) | (vrd << 7) | 32'h33;
`endif
            default: ill = 1;
        endcase
        if (ill) w = 32'h13;
        return {ill, w};
    endfunction

    function automatic vec_t mk(input int cls, input int func, input int rd, input int rs1,
                                input int rs2, input logic [31:0] imm,
                                input logic [31:0] ei, input bit eil);
        vec_t v;
        v.cls = 4'(cls); v.func = 4'(func); v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.imm = imm; v.exp_instr = ei; v.exp_ill = eil;
        return v;
    endfunction

    // Scoreboard monitor: samples 2 time units after each falling edge.
    logic [32:0] sb[$];
    bit          prev_stall = 0;
    logic [32:0] prev_word;
    always @(negedge iCLK) begin
        #2;
        if (prev_stall)
            check("stall_hold", {u_if.oValid, u_if.oIllegal, u_if.oInstr},
                  {1'b1, prev_word});
        if (iRST) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            if (u_if.iValid && u_if.oReady)
                sb.push_back(model(u_if.iClass, u_if.iFunc, u_if.iRd, u_if.iRs1,
                                   u_if.iRs2, u_if.iImm));
            if (u_if.oValid && u_if.iReady) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("unexpected_word", {u_if.oIllegal, u_if.oInstr}, 33'h1_DEAD_BEEF);
                end else begin
                    check("scoreboard", {u_if.oIllegal, u_if.oInstr}, sb.pop_front());
                end
            end
            prev_stall = u_if.oValid && !u_if.iReady;
            prev_word  = {u_if.oIllegal, u_if.oInstr};
        end
    end

    task automatic set_req(input logic [3:0] cls, input logic [3:0] func, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        u_if.iClass = cls; u_if.iFunc = func; u_if.iRd = rd;
        u_if.iRs1 = rs1; u_if.iRs2 = rs2; u_if.iImm = imm;
    endtask

    // Called at a falling edge; holds the request until it is accepted.
    task automatic send(input logic [3:0] cls, input logic [3:0] func, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int t = 0;
        set_req(cls, func, rd, rs1, rs2, imm);
        u_if.iValid = 1'b1;
        #1;
        while (!u_if.oReady && t < 50) begin
            @(negedge iCLK); #1; t++;
        end
        check("send_accept_timeout", {32'd0, u_if.oReady}, 33'd1);
        @(negedge iCLK);
        u_if.iValid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        u_if.iValid = 1'b0;
        u_if.iReady = 1'b1;
        while ((sb.size() != 0 || u_if.oValid) && t < 100) begin
            @(negedge iCLK); t++;
        end
        check("drain_timeout", {32'd0, (sb.size() == 0)}, 33'd1);
    endtask

    initial begin
        int lat;
        int base;
        logic [31:0] muldiv_exp;
        bit          muldiv_ill;
`ifdef RV32M_EN
        muldiv_exp = 32'h023100B3; muldiv_ill = 1'b0;
`else
        muldiv_exp = 32'h00000013; muldiv_ill = 1'b1;
`endif
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'd5,          32'h00500093, 0));
        vecs.push_back(mk(4, 8, 3, 1, 2, 32'd0,          32'h402081B3, 0));
        vecs.push_back(mk(6, 0, 0, 0, 0, 32'hFFFFFFFC,   32'hFE000EE3, 0));
        vecs.push_back(mk(5, 0, 5, 0, 0, 32'h12345000,   32'h123452B7, 0));
        vecs.push_back(mk(5, 0, 5, 0, 0, 32'h12345001,   32'h00000013, 1));
        vecs.push_back(mk(9, 0, 1, 2, 3, 32'd0,          muldiv_exp,   muldiv_ill));
        vecs.push_back(mk(9, 8, 1, 2, 3, 32'd0,          32'h00000013, 1));
        vecs.push_back(mk(0, 3, 1, 2, 0, 32'd0,          32'h00000013, 1));
        vecs.push_back(mk(7, 0, 1, 2, 0, 32'hFFFFFFFF,   32'hFFF100E7, 0));
        vecs.push_back(mk(8, 0, 1, 0, 0, 32'd2048,       32'h001000EF, 0));
        vecs.push_back(mk(8, 0, 1, 0, 0, 32'd3,          32'h00000013, 1));
        vecs.push_back(mk(1, 13, 1, 1, 0, 32'd3,         32'h4030D093, 0));
        vecs.push_back(mk(1, 1, 1, 1, 0, 32'd32,         32'h00000013, 1));
        vecs.push_back(mk(3, 2, 0, 2, 3, 32'd8,          32'h00312423, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'd2048,       32'h00000013, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 32'hFFFFF800,   32'h80000093, 0));
        vecs.push_back(mk(12, 0, 1, 0, 0, 32'd0,         32'h00000013, 1));
        vecs.push_back(mk(4, 9, 1, 1, 1, 32'd0,          32'h00000013, 1));
        vecs.push_back(mk(6, 2, 0, 0, 0, 32'd8,          32'h00000013, 1));
        vecs.push_back(mk(2, 0, 1, 0, 0, 32'h00001000,   32'h00001097, 0));

        iRST = 1'b1;
        u_if.iValid = 1'b0;
        u_if.iReady = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge iCLK);
        @(negedge iCLK);
        check("reset_state", {u_if.oValid, u_if.oIllegal, u_if.oInstr}, 34'd0);
        check("reset_ready", {32'd0, u_if.oReady}, 33'd1);
        iRST = 1'b0;
        u_if.iReady = 1'b1;

        foreach (vecs[k]) begin
            @(negedge iCLK);
            set_req(vecs[k].cls, vecs[k].func, vecs[k].rd, vecs[k].rs1, vecs[k].rs2, vecs[k].imm);
            u_if.iValid = 1'b1;
            @(negedge iCLK);
            u_if.iValid = 1'b0;
            lat = 1;
            while (!u_if.oValid && lat < 8) begin
                @(negedge iCLK); lat++;
            end
            check("vec_latency", 33'(lat), 33'd2);
            check("vec_word", {u_if.oIllegal, u_if.oInstr}, {vecs[k].exp_ill, vecs[k].exp_instr});
        end
        drain();

        // Four back-to-back requests with a three-cycle downstream stall.
        @(negedge iCLK);
        base = n_out;
        fork
            begin
                send(1, 0, 1, 0, 0, 32'd1);
                send(4, 0, 2, 3, 4, 32'd0);
                send(5, 0, 7, 0, 0, 32'hABCDE000);
                send(3, 1, 0, 5, 6, 32'hFFFFFFF0);
            end
            begin
                u_if.iReady = 1'b1;
                @(negedge iCLK);
                @(negedge iCLK);
                u_if.iReady = 1'b0;
                repeat (3) begin
                    #1;
                    check("stall_ready_low", {31'd0, u_if.oReady, u_if.oValid}, 33'd1);
                    @(negedge iCLK);
                end
                u_if.iReady = 1'b1;
            end
        join
        drain();
        check("stall_delivered", 33'(n_out - base), 33'd4);

        // Reset while both stages are full; neither word may emerge.
        @(negedge iCLK);
        u_if.iReady = 1'b0;
        send(1, 0, 9, 9, 0, 32'd9);
        send(5, 0, 9, 0, 0, 32'h00009000);
        check("both_full", {31'd0, u_if.oValid, u_if.oReady}, 33'd2);
        base = n_out;
        iRST = 1'b1;
        set_req(1, 0, 3, 3, 0, 32'd3);
        u_if.iValid = 1'b1;
        @(negedge iCLK);
        iRST = 1'b0;
        u_if.iValid = 1'b0;
        u_if.iReady = 1'b1;
        check("rst_flush_out", {u_if.oValid, u_if.oIllegal, u_if.oInstr}, 34'd0);
        check("rst_flush_ready", {32'd0, u_if.oReady}, 33'd1);
        repeat (4) @(negedge iCLK);
        check("rst_no_words", 33'(n_out - base), 33'd0);

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            int kind;
            logic [31:0] imm;
            int bnd[18] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                            -1048577, -1048576, 1048574, 1048575, 1048576, 31, 32, -1, 0};
            @(negedge iCLK);
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: imm = 32'($signed(int'($urandom_range(0, 80)) - 40));
                1: imm = $urandom;
                2: imm = 32'(bnd[$urandom_range(0, 17)]);
                3: imm = $urandom & 32'hFFFFF000;
                4: imm = 32'($signed(int'($urandom_range(0, 8192)) - 4096));
                default: imm = 32'($urandom_range(0, 40));
            endcase
            set_req(($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 9)),
                    ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 7)),
                    5'($urandom), 5'($urandom), 5'($urandom), imm);
            u_if.iValid = ($urandom_range(0, 3) != 0);
            u_if.iReady = ($urandom_range(0, 3) != 0);
            iRST = ($urandom_range(0, 399) == 0);
        end
        @(negedge iCLK);
        iRST = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
